spi_xfer_sequencer: RTL and testbench
=====================================

Name: spi_xfer_sequencer

Overview:
Wishbone-master sequencer that drives the spi_top register interface on behalf of one client. It accepts a transfer request (data, length, divider, slave select, mode) and issues the DIVIDE/TX_0/CTRL/SS/GO write sequence. It then polls CTRL.BSY, reads RX_0, releases SS and returns the received word with a status code. It sits between client logic and spi_top, replacing the hand-written bus sequence used in bench bring-up.

Parameters:
POLL_GAP, 4, idle cycles between consecutive BSY polls (0 = back-to-back)
POLL_MAX, 65535, maximum BSY polls before timeout (16-bit counter)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset; asynchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_tx_i  in  32  transmit word, right-aligned
req_len_i  in  6  char length, legal 1..32
req_div_i  in  16  SPI_DIVIDE value
req_ss_i  in  8  SPI_SS value
req_mode_i  in  3  {lsb, tx_negedge, rx_negedge} -> CTRL[11], CTRL[10], CTRL[9]
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rx_o  out  32  received word, bits >= len forced to 0
rsp_status_o  out  2  0 ok, 1 bus error, 2 timeout, 3 bad length
wb_adr_o  out  5  register address (DIVIDE 0x14, TX_0 0x00, CTRL 0x10, SS 0x18, RX_0 0x00)
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_sel_o  out  4  always 4'hf during a cycle
wb_we_o  out  1  write enable
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error

Behaviour:
- Reset (async, wb_rst_i=0): state IDLE. req_ready_o=0, rsp_valid_o=0, rsp_rx_o=0, rsp_status_o=0, wb_cyc_o/stb_o/we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0. Reset mid-transaction abandons the bus cycle immediately; SS is not released by this block.
- req_ready_o=1 only in IDLE. A request is captured into internal registers on the valid&ready edge.
- Each bus access is a single classic cycle: cyc=stb=1 with address, data and we held stable until ack or err. Both drop in the cycle after the ack/err edge. There is one idle cycle between accesses.
- States: IDLE -> CHK -> WR_DIV -> WR_TX -> WR_CTRL -> WR_SS -> WR_GO -> POLL_RD -> POLL_GAP -> RD_RX -> WR_SSCLR -> RESP -> IDLE.
- CHK: if len=0 or len>32, go to RESP with status 3 and no bus traffic.
- CTRL value = {mode, 1'b0 GO, 2'b0, len} mapped to bits [11:9], [8], [7:0], with len=32 encoded as 8'h20. WR_GO rewrites the same value with bit 8 set.
- POLL_RD reads CTRL. If bit 8=0, go to RD_RX. Otherwise increment the poll count; if count=POLL_MAX go to WR_SSCLR with pending status 2, else wait POLL_GAP cycles and repeat.
- RD_RX: rsp_rx_o <= wb_dat_i & ((1<<len)-1), computed in 33-bit arithmetic so len=32 yields all-ones.
- WR_SSCLR writes SS=0, then the FSM enters RESP.
- wb_err_i in any state: end the cycle, skip all further accesses (including WR_SSCLR), go to RESP with status 1.
- RESP: rsp_valid_o=1 and held with stable data until rsp_ready_i=1, then return to IDLE. rsp_rx_o holds its last value otherwise.
- Transfer latency, ok path with zero-wait ack: 7 accesses plus polls.

Optional Feature:
SPI_SEQ_DIV_CACHE_EN:
- Defined: a "div valid" flag and the last written divider are held (cleared on reset or bus error). WR_DIV is skipped when the flag is set and req_div_i equals the cached value.
- Undefined: DIVIDE is written on every request.

Decomposition:
- Package spi_seq_pkg holds the register address constants (SPI_TX_0, SPI_RX_0, SPI_CTRL, SPI_DIVIDE, SPI_SS), the CTRL bit positions (GO=8, RX_NEG=9, TX_NEG=10, LSB=11), the status codes and the FSM state encoding.
- One sub-module, spi_seq_wb_port: single-access Wishbone engine (start, we, adr, dat -> done, err, rdata). The top FSM sequences it.

Test Plan:
- req tx=0x800950, len=24, div=1, ss=0x01, mode=3'b001, slave returns 0xa5 -> bus writes DIVIDE=0x01, TX_0=0x800950, CTRL=0x218, SS=0x01, CTRL=0x318; polls; RX_0 read; SS=0; rsp_rx=0x0000a5, status 0.
- len=0, then len=40 -> no wb_cyc_o assertion, status 3 both times.
- wb_err_i on the WR_SS ack -> no further cycles, status 1, rsp_rx unchanged.
- BSY stuck at 1 with POLL_MAX=3 -> exactly 3 CTRL reads, SS=0 write, status 2.
- rsp_ready_i held low 10 cycles -> rsp_valid_o and data stable, req_ready_o=0. Async reset asserted mid-POLL -> all outputs 0 at once.
- With SPI_SEQ_DIV_CACHE_EN, two requests with div=1 -> DIVIDE written once; a third request with div=2 -> DIVIDE written again.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared definitions for the SPI transfer sequencer.
// Holds the spi_top register map, CTRL bit positions, response status
// codes, the sequencer FSM state encoding and two small helpers that
// build the CTRL word and the received-word mask.
package spi_seq_pkg;

  // spi_top register addresses (TX_0 and RX_0 share an address).
  localparam logic [4:0] SPI_TX_0   = 5'h00;
  localparam logic [4:0] SPI_RX_0   = 5'h00;
  localparam logic [4:0] SPI_CTRL   = 5'h10;
  localparam logic [4:0] SPI_DIVIDE = 5'h14;
  localparam logic [4:0] SPI_SS     = 5'h18;

  // CTRL bit positions.
  localparam int CTRL_GO     = 8;
  localparam int CTRL_RX_NEG = 9;
  localparam int CTRL_TX_NEG = 10;
  localparam int CTRL_LSB    = 11;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BUS_ERR = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_BAD_LEN = 2'd3
  } status_e;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CHK      = 4'd1,
    S_WR_DIV   = 4'd2,
    S_WR_TX    = 4'd3,
    S_WR_CTRL  = 4'd4,
    S_WR_SS    = 4'd5,
    S_WR_GO    = 4'd6,
    S_POLL_RD  = 4'd7,
    S_POLL_GAP = 4'd8,
    S_RD_RX    = 4'd9,
    S_WR_SSCLR = 4'd10,
    S_RESP     = 4'd11
  } state_e;

  // CTRL word: mode bits, GO, and the char length in [7:0] (32 -> 8'h20).
  function automatic logic [31:0] ctrl_word(input logic [2:0] mode,
                                            input logic [5:0] len,
                                            input logic       go);
    logic [31:0] w;
    w              = 32'h0000_0000;
    w[CTRL_LSB]    = mode[2];
    w[CTRL_TX_NEG] = mode[1];
    w[CTRL_RX_NEG] = mode[0];
    w[CTRL_GO]     = go;
    w[7:0]         = {2'b00, len};
    return w;
  endfunction

  // Low-len-bits mask; 33-bit arithmetic so len=32 gives all ones.
  function automatic logic [31:0] rx_mask(input logic [5:0] len);
    return 32'((33'd1 << len) - 33'd1);
  endfunction

endpackage

// File: rtl/spi_seq_wb_port.sv
// spi_seq_wb_port: single-access Wishbone classic-cycle engine.
// A one-cycle start_i pulse (sampled while idle) latches we/adr/dat and
// raises cyc/stb; they stay stable until ack or err, and drop on the
// clock edge that samples the response. done_o/err_o flag that edge
// combinationally; rdata_o is the bus read data for the same cycle.
// Ports: clk_i, rst_ni (async active-low), start_i, we_i, adr_i, dat_i,
//        done_o, err_o, rdata_o, Wishbone master signals wb_*.
module spi_seq_wb_port (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [4:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [4:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;

  // Next-state for the bus cycle: open on start, close on ack/err.
  always_comb begin
    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    if (cyc_q) begin
      if (wb_ack_i || wb_err_i) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        sel_d = 4'h0;
      end else begin
        cyc_d = 1'b1;
      end
    end else if (start_i) begin
      cyc_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = dat_i;
      sel_d = 4'hf;
    end else begin
      cyc_d = 1'b0;
    end
  end

  // Bus output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= 5'h00;
      dat_q <= 32'h0000_0000;
      sel_q <= 4'h0;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
    end
  end

  assign done_o   = cyc_q & wb_ack_i & ~wb_err_i;
  assign err_o    = cyc_q & wb_err_i;
  assign rdata_o  = wb_dat_i;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;

endmodule

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: Wishbone-master sequencer for spi_top.
// Accepts one request (tx word, length, divider, SS, mode), writes
// DIVIDE/TX_0/CTRL/SS/CTRL+GO, polls CTRL.BSY, reads RX_0, clears SS
// and returns the masked received word with a status code.
// Ports: wb_clk_i, wb_rst_i (async active-low); req_* request handshake;
//        rsp_* response handshake; wb_* Wishbone master to spi_top.
// Parameters: POLL_GAP idle cycles between polls, POLL_MAX poll limit.
// Optional: define SPI_SEQ_DIV_CACHE_EN to skip rewriting an unchanged
//           divider.
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 65535
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_tx_i,
  input  logic [5:0]  req_len_i,
  input  logic [15:0] req_div_i,
  input  logic [7:0]  req_ss_i,
  input  logic [2:0]  req_mode_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rx_o,
  output logic [1:0]  rsp_status_o,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic [31:0] tx_q, tx_d;
  logic [5:0]  len_q, len_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  ss_q, ss_d;
  logic [2:0]  mode_q, mode_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  status_e     pend_q, pend_d;
  status_e     status_q, status_d;
  logic [31:0] rx_q, rx_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        req_ready_q, req_ready_d;

  logic        acc_we_s;
  logic [4:0]  acc_adr_s;
  logic [31:0] acc_dat_s;
  logic        done_s, err_s;
  logic [31:0] rdata_s;
  logic        div_hit_s;
  logic        len_bad_s;

  assign len_bad_s = (len_q == 6'd0) || (len_q > 6'd32);

`ifdef SPI_SEQ_DIV_CACHE_EN
  logic        div_vld_q, div_vld_d;
  logic [15:0] div_cache_q, div_cache_d;

  assign div_hit_s = div_vld_q && (div_cache_q == div_q);

  // Divider cache: filled by a clean DIVIDE write, dropped on any bus error.
  always_comb begin
    div_vld_d   = div_vld_q;
    div_cache_d = div_cache_q;
    if (err_s) begin
      div_vld_d = 1'b0;
    end else if (done_s && (state_q == S_WR_DIV)) begin
      div_vld_d   = 1'b1;
      div_cache_d = div_q;
    end else begin
      div_vld_d = div_vld_q;
    end
  end

  // Divider cache registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      div_vld_q   <= 1'b0;
      div_cache_q <= 16'h0000;
    end else begin
      div_vld_q   <= div_vld_d;
      div_cache_q <= div_cache_d;
    end
  end
`else
  assign div_hit_s = 1'b0;
`endif

  // Access descriptor for the current state; latched by the port on start.
  always_comb begin
    acc_we_s  = 1'b0;
    acc_adr_s = 5'h00;
    acc_dat_s = 32'h0000_0000;
    case (state_q)
      S_WR_DIV:   begin acc_we_s = 1'b1; acc_adr_s = SPI_DIVIDE; acc_dat_s = {16'h0000, div_q}; end
      S_WR_TX:    begin acc_we_s = 1'b1; acc_adr_s = SPI_TX_0;   acc_dat_s = tx_q; end
      S_WR_CTRL:  begin acc_we_s = 1'b1; acc_adr_s = SPI_CTRL;   acc_dat_s = ctrl_word(mode_q, len_q, 1'b0); end
      S_WR_SS:    begin acc_we_s = 1'b1; acc_adr_s = SPI_SS;     acc_dat_s = {24'h000000, ss_q}; end
      S_WR_GO:    begin acc_we_s = 1'b1; acc_adr_s = SPI_CTRL;   acc_dat_s = ctrl_word(mode_q, len_q, 1'b1); end
      S_POLL_RD:  begin acc_we_s = 1'b0; acc_adr_s = SPI_CTRL;   acc_dat_s = 32'h0000_0000; end
      S_RD_RX:    begin acc_we_s = 1'b0; acc_adr_s = SPI_RX_0;   acc_dat_s = 32'h0000_0000; end
      S_WR_SSCLR: begin acc_we_s = 1'b1; acc_adr_s = SPI_SS;     acc_dat_s = 32'h0000_0000; end
      default:    begin acc_we_s = 1'b0; acc_adr_s = 5'h00;      acc_dat_s = 32'h0000_0000; end
    endcase
  end

  // Sequencer next-state; start_d pulses on entry to each access state.
  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    tx_d        = tx_q;
    len_d       = len_q;
    div_d       = div_q;
    ss_d        = ss_q;
    mode_d      = mode_q;
    poll_cnt_d  = poll_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pend_d      = pend_q;
    status_d    = status_q;
    rx_d        = rx_q;
    rsp_valid_d = rsp_valid_q;
    if (err_s) begin
      // A bus error abandons the sequence, SS clear included.
      state_d     = S_RESP;
      status_d    = ST_BUS_ERR;
      rsp_valid_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            tx_d    = req_tx_i;
            len_d   = req_len_i;
            div_d   = req_div_i;
            ss_d    = req_ss_i;
            mode_d  = req_mode_i;
            state_d = S_CHK;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CHK: begin
          poll_cnt_d = 16'h0000;
          pend_d     = ST_OK;
          if (len_bad_s) begin
            state_d     = S_RESP;
            status_d    = ST_BAD_LEN;
            rsp_valid_d = 1'b1;
          end else if (div_hit_s) begin
            state_d = S_WR_TX;
            start_d = 1'b1;
          end else begin
            state_d = S_WR_DIV;
            start_d = 1'b1;
          end
        end
        S_WR_DIV:  begin if (done_s) begin state_d = S_WR_TX;   start_d = 1'b1; end else begin state_d = S_WR_DIV;  end end
        S_WR_TX:   begin if (done_s) begin state_d = S_WR_CTRL; start_d = 1'b1; end else begin state_d = S_WR_TX;   end end
        S_WR_CTRL: begin if (done_s) begin state_d = S_WR_SS;   start_d = 1'b1; end else begin state_d = S_WR_CTRL; end end
        S_WR_SS:   begin if (done_s) begin state_d = S_WR_GO;   start_d = 1'b1; end else begin state_d = S_WR_SS;   end end
        S_WR_GO:   begin if (done_s) begin state_d = S_POLL_RD; start_d = 1'b1; end else begin state_d = S_WR_GO;   end end
        S_POLL_RD: begin
          if (!done_s) begin
            state_d = S_POLL_RD;
          end else if (!rdata_s[CTRL_GO]) begin
            state_d = S_RD_RX;
            start_d = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
            if (poll_cnt_d == 16'(POLL_MAX)) begin
              state_d = S_WR_SSCLR;
              start_d = 1'b1;
              pend_d  = ST_TIMEOUT;
            end else if (POLL_GAP == 0) begin
              state_d = S_POLL_RD;
              start_d = 1'b1;
            end else begin
              state_d   = S_POLL_GAP;
              gap_cnt_d = 16'(POLL_GAP - 1);
            end
          end
        end
        S_POLL_GAP: begin
          if (gap_cnt_q == 16'h0000) begin
            state_d = S_POLL_RD;
            start_d = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 16'd1;
          end
        end
        S_RD_RX: begin
          if (done_s) begin
            rx_d    = rdata_s & rx_mask(len_q);
            state_d = S_WR_SSCLR;
            start_d = 1'b1;
          end else begin
            state_d = S_RD_RX;
          end
        end
        S_WR_SSCLR: begin
          if (done_s) begin
            state_d     = S_RESP;
            status_d    = pend_q;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = S_WR_SSCLR;
          end
        end
        S_RESP: begin
          if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_d = (state_d == S_IDLE);

  // Sequencer state and request/response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      tx_q        <= 32'h0000_0000;
      len_q       <= 6'd0;
      div_q       <= 16'h0000;
      ss_q        <= 8'h00;
      mode_q      <= 3'b000;
      poll_cnt_q  <= 16'h0000;
      gap_cnt_q   <= 16'h0000;
      pend_q      <= ST_OK;
      status_q    <= ST_OK;
      rx_q        <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      tx_q        <= tx_d;
      len_q       <= len_d;
      div_q       <= div_d;
      ss_q        <= ss_d;
      mode_q      <= mode_d;
      poll_cnt_q  <= poll_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pend_q      <= pend_d;
      status_q    <= status_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  spi_seq_wb_port u_port (
    .clk_i    (wb_clk_i),
    .rst_ni   (wb_rst_i),
    .start_i  (start_q),
    .we_i     (acc_we_s),
    .adr_i    (acc_adr_s),
    .dat_i    (acc_dat_s),
    .done_o   (done_s),
    .err_o    (err_s),
    .rdata_o  (rdata_s),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rx_o     = rx_q;
  assign rsp_status_o = status_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer with a behavioural spi_top
// slave (random wait states, programmable BSY polls, error injection) and
// a transaction-level reference model of the expected bus sequence.
module tb_spi_xfer_sequencer;

  localparam int TB_POLL_GAP = 2;
  localparam int TB_POLL_MAX = 3;
  localparam logic [4:0] A_TX = 5'h00, A_RX = 5'h00, A_CTRL = 5'h10, A_DIV = 5'h14, A_SS = 5'h18;
  localparam int NO_ERR = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_tx = 32'h0;
  logic [5:0]  req_len = 6'd0;
  logic [15:0] req_div = 16'h0;
  logic [7:0]  req_ss = 8'h0;
  logic [2:0]  req_mode = 3'b000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rx;
  logic [1:0]  rsp_status;
  logic [4:0]  wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;

  always #5 clk = ~clk;

  spi_xfer_sequencer #(.POLL_GAP(TB_POLL_GAP), .POLL_MAX(TB_POLL_MAX)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_tx_i(req_tx),
    .req_len_i(req_len), .req_div_i(req_div), .req_ss_i(req_ss), .req_mode_i(req_mode),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rx_o(rsp_rx), .rsp_status_o(rsp_status),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel),
    .wb_we_o(wb_we), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [37:0] log_q[$];
  int          busy_left = 0;
  logic [31:0] rx_word = 32'h0;
  int          err_at = NO_ERR;
  int          acc_idx = 0;
  bit          in_cyc = 0;
  int          wcnt = 0;
  logic [37:0] snap;

  always @(negedge clk) begin
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_dat_i = 32'h0;
    if (!rst_n || !wb_cyc) begin
      in_cyc = 0;
    end else begin
      if (!in_cyc) begin
        in_cyc = 1;
        wcnt   = $urandom_range(0, 2);
        snap   = {wb_we, wb_adr, wb_dat_o};
      end
      chk("bus_stable", {wb_stb, wb_sel, wb_we, wb_adr, wb_dat_o}, {1'b1, 4'hf, snap});
      if (wcnt > 0) begin
        wcnt--;
      end else begin
        log_q.push_back({wb_we, wb_adr, wb_we ? wb_dat_o : 32'h0});
        if (acc_idx == err_at) wb_err = 1'b1;
        else wb_ack = 1'b1;
        if (!wb_we && wb_adr == A_CTRL) begin
          wb_dat_i = ($urandom() & ~32'h100) | ((busy_left > 0) ? 32'h100 : 32'h0);
          if (busy_left > 0) busy_left--;
        end else if (!wb_we) begin
          wb_dat_i = rx_word;
        end else begin
          wb_dat_i = $urandom();
        end
        acc_idx++;
      end
    end
  end

  // ---------------- reference model ----------------
  logic        m_cvld = 1'b0;
  logic [15:0] m_cdiv = 16'h0;
  logic [31:0] m_rx = 32'h0;
  logic [37:0] exp_q[$];
  logic [1:0]  exp_st;

  function automatic bit div_hit(input logic [15:0] d);
`ifdef SPI_SEQ_DIV_CACHE_EN
    return m_cvld && (m_cdiv == d);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] tb_mask(input int len);
    if (len >= 32) return 32'hffff_ffff;
    return (32'h1 << len) - 32'h1;
  endfunction

  task automatic build_exp(input logic [31:0] tx, input logic [5:0] len, input logic [15:0] div,
                           input logic [7:0] ss, input logic [2:0] mode, input int busy,
                           input logic [31:0] rxw, input int e);
    int rx_idx;
    bit div_wr;
    int npoll;
    logic [31:0] ctrl;
    rx_idx = -1;
    div_wr = 0;
    exp_q.delete();
    if (len == 6'd0 || len > 6'd32) begin
      exp_st = 2'd3;
    end else begin
      ctrl = (32'(mode) << 9) | 32'(len);
      if (!div_hit(div)) begin exp_q.push_back({1'b1, A_DIV, 32'(div)}); div_wr = 1; end
      exp_q.push_back({1'b1, A_TX, tx});
      exp_q.push_back({1'b1, A_CTRL, ctrl});
      exp_q.push_back({1'b1, A_SS, 32'(ss)});
      exp_q.push_back({1'b1, A_CTRL, ctrl | 32'h100});
      npoll = (busy >= TB_POLL_MAX) ? TB_POLL_MAX : busy + 1;
      for (int i = 0; i < npoll; i++) exp_q.push_back({1'b0, A_CTRL, 32'h0});
      if (busy < TB_POLL_MAX) begin rx_idx = exp_q.size(); exp_q.push_back({1'b0, A_RX, 32'h0}); end
      exp_q.push_back({1'b1, A_SS, 32'h0});
      exp_st = (busy >= TB_POLL_MAX) ? 2'd2 : 2'd0;
      if (e < exp_q.size()) begin
        while (exp_q.size() > e + 1) void'(exp_q.pop_back());
        exp_st = 2'd1;
      end
      if (rx_idx >= 0 && (exp_st != 2'd1 || rx_idx < e)) m_rx = rxw & tb_mask(int'(len));
      if (exp_st == 2'd1) m_cvld = 1'b0;
      else if (div_wr) begin m_cvld = 1'b1; m_cdiv = div; end
    end
  endtask

  task automatic send_req(input string tag, input logic [31:0] tx, input logic [5:0] len,
                          input logic [15:0] div, input logic [7:0] ss, input logic [2:0] mode);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_tx = tx; req_len = len; req_div = div; req_ss = ss; req_mode = mode;
    k = 0;
    while (!req_ready && k < 200) begin @(negedge clk); k++; end
    chk({tag, "_accept"}, 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_tx = $urandom(); req_len = 6'($urandom()); req_div = 16'($urandom());
    req_ss = 8'($urandom()); req_mode = 3'($urandom());
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] tx, input logic [5:0] len,
                          input logic [15:0] div, input logic [7:0] ss, input logic [2:0] mode,
                          input int busy, input logic [31:0] rxw, input int e, input int hold);
    int k;
    int n;
    build_exp(tx, len, div, ss, mode, busy, rxw, e);
    log_q.delete(); acc_idx = 0; busy_left = busy; rx_word = rxw; err_at = e;
    send_req(tag, tx, len, div, ss, mode);
    k = 0;
    while (!rsp_valid && k < 3000) begin @(negedge clk); k++; end
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
    chk({tag, "_status"}, 64'(rsp_status), 64'(exp_st));
    chk({tag, "_rx"}, 64'(rsp_rx), 64'(m_rx));
    chk({tag, "_nacc"}, 64'(log_q.size()), 64'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_acc%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {rsp_valid, req_ready, rsp_status, rsp_rx}, {1'b1, 1'b0, exp_st, m_rx});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_released"}, {rsp_valid, req_ready, wb_cyc}, {1'b0, 1'b1, 1'b0});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rsp"}, {req_ready, rsp_valid, rsp_status, rsp_rx}, 64'h0);
    chk({tag, "_bus"}, {wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o}, 64'h0);
  endtask

  initial begin
    int e;
    int k;
    int n_pre;
    #2;
    check_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'(1));

    // Reference transfer, then bad lengths.
    run_xfer("basic", 32'h0080_0950, 6'd24, 16'd1, 8'h01, 3'b001, 2, 32'h0000_00a5, NO_ERR, 0);
    run_xfer("len0", 32'h1111_1111, 6'd0, 16'd1, 8'h01, 3'b000, 0, 32'hffff_ffff, NO_ERR, 0);
    run_xfer("len40", 32'h2222_2222, 6'd40, 16'd1, 8'h01, 3'b000, 0, 32'hffff_ffff, NO_ERR, 0);
    // Error on the SS write ack.
    e = div_hit(16'd1) ? 2 : 3;
    run_xfer("err_ss", 32'hdead_beef, 6'd8, 16'd1, 8'h02, 3'b010, 0, 32'h5555_5555, e, 0);
    // BSY stuck: POLL_MAX polls then SS clear, timeout.
    run_xfer("timeout", 32'h0000_0f0f, 6'd12, 16'd4, 8'h04, 3'b100, 10, 32'h1234_5678, NO_ERR, 0);
    // Length boundaries; response held off for 10 cycles.
    run_xfer("len32_hold", 32'h8765_4321, 6'd32, 16'd4, 8'h08, 3'b111, 0, 32'hcafe_f00d, NO_ERR, 10);
    run_xfer("len1", 32'h0000_0001, 6'd1, 16'd4, 8'h10, 3'b000, 1, 32'hffff_fffe, NO_ERR, 0);
    run_xfer("len33", 32'h0000_0001, 6'd33, 16'd4, 8'h10, 3'b000, 1, 32'hffff_ffff, NO_ERR, 0);
    // Divider repeat / change.
    run_xfer("div_a", 32'h0000_00aa, 6'd8, 16'd1, 8'h01, 3'b000, 0, 32'h0000_0033, NO_ERR, 0);
    run_xfer("div_b", 32'h0000_00bb, 6'd8, 16'd1, 8'h01, 3'b000, 0, 32'h0000_0044, NO_ERR, 0);
    run_xfer("div_c", 32'h0000_00cc, 6'd8, 16'd2, 8'h01, 3'b000, 0, 32'h0000_0055, NO_ERR, 0);

    // Randomized transfers.
    for (int i = 0; i < 15; i++) begin
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : NO_ERR;
      run_xfer($sformatf("rnd%0d", i), $urandom(), 6'($urandom_range(0, 40)), 16'($urandom_range(1, 3)),
               8'($urandom()), 3'($urandom_range(0, 7)), $urandom_range(0, 4), $urandom(), e,
               $urandom_range(0, 3));
    end

    // Async reset while polling.
    n_pre = div_hit(16'd7) ? 4 : 5;
    build_exp(32'h0bad_0bad, 6'd16, 16'd7, 8'h20, 3'b001, 50, 32'h0, NO_ERR);
    log_q.delete(); acc_idx = 0; busy_left = 50; rx_word = 32'h0; err_at = NO_ERR;
    send_req("rst_poll", 32'h0bad_0bad, 6'd16, 16'd7, 8'h20, 3'b001);
    k = 0;
    while (log_q.size() <= n_pre && k < 500) begin @(negedge clk); k++; end
    chk("rst_poll_reached", 64'(log_q.size() > n_pre), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_poll");
    m_cvld = 1'b0; m_rx = 32'h0; busy_left = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_poll_ready", 64'(req_ready), 64'(1));
    run_xfer("after_rst", 32'h00ab_cdef, 6'd20, 16'd7, 8'h01, 3'b011, 0, 32'hffff_ffff, NO_ERR, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
